drip_pulse_generator: RTL and testbench



---
 rtl/drip_pulse_generator.sv | 94 +++++++++
 tb/tb_drip_pulse_generator.sv | 132 +++++++++++++
 2 files changed

// File: rtl/drip_pulse_generator.sv
// drip_pulse_generator: emits a BCD-programmed count of fixed-width drip pulses
module drip_pulse_generator #(
    parameter int PULSE_HIGH = 4,
    parameter int PULSE_GAP  = 4,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] target_units,
    input  logic [3:0] target_tens,
    output logic       pulse,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] rem_units,
    output logic [3:0] rem_tens
);
    typedef enum logic [1:0] {IDLE, HIGH, GAP, DONE} state_t;
    localparam logic [CNT_W-1:0] high_last = CNT_W'(PULSE_HIGH - 1);
    localparam logic [CNT_W-1:0] gap_last  = CNT_W'(PULSE_GAP - 1);
    state_t state;
    logic [CNT_W-1:0] cnt;
    logic bad_target, zero_target, last_drop;
    assign bad_target  = (target_units > 4'd9) || (target_tens > 4'd9);
    assign zero_target = (target_units == 4'd0) && (target_tens == 4'd0);
    assign last_drop   = (rem_tens == 4'd0) && (rem_units == 4'd1);
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state     <= IDLE;
            cnt       <= '0;
            pulse     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rem_units <= 4'd0;
            rem_tens  <= 4'd0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        if (bad_target) begin
                            err <= 1'b1;
                        end else if (zero_target) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= HIGH;
                            cnt       <= '0;
                            pulse     <= 1'b1;
                            busy      <= 1'b1;
                            rem_units <= target_units;
                            rem_tens  <= target_tens;
                        end
                    end
                end
                HIGH: begin
                    if (abort) begin
                        state <= IDLE;
                        pulse <= 1'b0;
                        busy  <= 1'b0;
                    end else if (cnt == high_last) begin
                        // BCD decrement with borrow from tens when units is zero
                        rem_units <= (rem_units == 4'd0) ? 4'd9 : rem_units - 4'd1;
                        rem_tens  <= (rem_units == 4'd0) ? rem_tens - 4'd1 : rem_tens;
                        cnt       <= '0;
                        pulse     <= 1'b0;
                        state     <= last_drop ? DONE : GAP;
                        busy      <= !last_drop;
                        done      <= last_drop;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == gap_last) begin
                        state <= HIGH;
                        cnt   <= '0;
                        pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_drip_pulse_generator.sv
// tb_drip_pulse_generator: directed checks of drop count, timing, abort, err and async clear
module tb_drip_pulse_generator;
    logic clk = 1'b0;
    logic clear = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [3:0] target_units = 4'd0;
    logic [3:0] target_tens = 4'd0;
    logic pulse, busy, done, err;
    logic [3:0] rem_units, rem_tens;
    int n_pass = 0;
    int n_chk = 0;
    drip_pulse_generator dut (
        .clk(clk), .clear(clear), .start(start), .abort(abort),
        .target_units(target_units), .target_tens(target_tens),
        .pulse(pulse), .busy(busy), .done(done), .err(err),
        .rem_units(rem_units), .rem_tens(rem_tens)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic do_start(input logic [3:0] tt, input logic [3:0] tu);
        target_tens = tt;
        target_units = tu;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask
    // samples from the current cycle onwards for a fixed number of cycles
    task automatic run(input int cycles, output int nbusy, output int npulse, output int nhigh,
                       output int ndone, output logic done_ok, output logic [7:0] rem_at4);
        logic prev_p;
        int last_busy, done_idx;
        prev_p = 1'b0;
        nbusy = 0; npulse = 0; nhigh = 0; ndone = 0;
        last_busy = -10; done_idx = -1; rem_at4 = 8'hff;
        for (int i = 0; i < cycles; i++) begin
            if (busy) begin nbusy++; last_busy = i; end
            if (pulse) nhigh++;
            if (pulse && !prev_p) npulse++;
            prev_p = pulse;
            if (done) begin ndone++; done_idx = i; end
            if (i == 4) rem_at4 = {rem_tens, rem_units};
            tick();
        end
        done_ok = (done_idx == last_busy + 1);
    endtask
    initial begin
        int nb, np, nh, nd, rises;
        logic ok, prev;
        logic [7:0] r4;
        #12;
        check("reset_outs", {pulse, busy, done, err}, 4'b0000);
        check("reset_rem", {rem_tens, rem_units}, 8'h00);
        clear = 1'b1;
        tick();
        // three drops
        do_start(4'd0, 4'd3);
        run(30, nb, np, nh, nd, ok, r4);
        check("t03_busy", nb, 20);
        check("t03_pulses", np, 3);
        check("t03_high", nh, 12);
        check("t03_done", nd, 1);
        check("t03_done_after_busy", ok, 1'b1);
        check("t03_rem_step", r4, 8'h02);
        check("t03_rem_end", {rem_tens, rem_units}, 8'h00);
        // ten drops with a borrow on the first decrement
        do_start(4'd1, 4'd0);
        run(90, nb, np, nh, nd, ok, r4);
        check("t10_busy", nb, 76);
        check("t10_pulses", np, 10);
        check("t10_borrow", r4, 8'h09);
        check("t10_done", nd, 1);
        check("t10_done_after_busy", ok, 1'b1);
        check("t10_rem_end", {rem_tens, rem_units}, 8'h00);
        // zero target goes straight to DONE
        do_start(4'd0, 4'd0);
        check("t00_done", {done, busy, pulse}, 3'b100);
        tick();
        run(6, nb, np, nh, nd, ok, r4);
        check("t00_quiet", {nb[7:0], np[7:0], nd[7:0]}, 24'h0);
        // abort during the second gap, with a stray start mid-run
        do_start(4'd0, 4'd5);
        rises = 0; prev = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (pulse && !prev) rises++;
            prev = pulse;
            start = (i == 2);
            target_tens = (i == 2) ? 4'd0 : target_tens;
            target_units = (i == 2) ? 4'd9 : target_units;
            abort = (i == 13);
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        check("ab_pulses_before", rises, 2);
        check("ab_outs", {pulse, busy, done}, 3'b000);
        check("ab_rem", {rem_tens, rem_units}, 8'h03);
        run(12, nb, np, nh, nd, ok, r4);
        check("ab_quiet", {nb[7:0], np[7:0], nd[7:0]}, 24'h0);
        // invalid digit flags err and leaves everything else alone
        do_start(4'd0, 4'hA);
        check("err_strobe", {err, busy, pulse, done}, 4'b1000);
        check("err_rem", {rem_tens, rem_units}, 8'h03);
        tick();
        check("err_one_cycle", err, 1'b0);
        // asynchronous clear in the middle of a HIGH phase
        do_start(4'd0, 4'd7);
        tick();
        check("clr_pre_busy", {pulse, busy}, 2'b11);
        #2 clear = 1'b0;
        #1;
        check("clr_outs", {pulse, busy}, 2'b00);
        check("clr_rem", {rem_tens, rem_units}, 8'h00);
        clear = 1'b1;
        tick();
        do_start(4'd0, 4'd2);
        run(20, nb, np, nh, nd, ok, r4);
        check("clr_t02_pulses", np, 2);
        check("clr_t02_busy", nb, 12);
        check("clr_t02_done", nd, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
